// File: rtl/dsp_conv_pkg.sv
// Shared types and sizing helpers for the convolution kernel-load path.
// The FSM state encoding and the per-kernel word count live here so every user agrees on them.
package dsp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SWAP = 2'd2,
    DONE = 2'd3
  } krnl_state_t;

  // One kernel is KERN_SZ x KERN_SZ taps across every image plane.
  function automatic int krnl_words(input int kern_sz, input int img_d);
    return kern_sz * kern_sz * img_d;
  endfunction

endpackage

// File: rtl/dsp_onehot_dec.sv
// Binary tile index to one-hot tile vector; all bits stay low while i_en is low.
module dsp_onehot_dec #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         i_en,
  input  logic [W-1:0] i_idx,
  output logic [N-1:0] o_onehot
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign o_onehot[gi] = i_en && (i_idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dsp_krnl_load_ctrl.sv
// Streams one kernel's weight words into a single tile's kernel BRAM bank, then
// optionally pulses that tile's kernel-swap strobe and reports completion.
module dsp_krnl_load_ctrl
  import dsp_conv_pkg::*;
#(
  parameter int NUM_TILES = 480,
  parameter int KERN_SZ   = 3,
  parameter int IMG_D     = 6,
  parameter int A_W       = 14,
  parameter int M_W       = 18,
  localparam int KRNL_WORDS = krnl_words(KERN_SZ, IMG_D),
  localparam int TILE_W     = $clog2(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TILE_W-1:0]    cmd_tile,
  input  logic                 cmd_bank,
  input  logic                 cmd_swap,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [M_W-1:0]       s_data,
  output logic [A_W-1:0]       krnl_wraddr,
  output logic [M_W-1:0]       krnl_wrdata,
  output logic [NUM_TILES-1:0] krnl_bram1_wren,
  output logic [NUM_TILES-1:0] krnl_bram2_wren,
  output logic [NUM_TILES-1:0] ld_new_kernel,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err
);

  localparam int                 CNT_W    = $clog2(KRNL_WORDS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(KRNL_WORDS - 1);
  // One extra bit so a power-of-two tile count still compares correctly.
  localparam logic [TILE_W:0]    TILE_LIM = (TILE_W + 1)'(NUM_TILES);

  krnl_state_t          r_state;
  krnl_state_t          w_state_next;
  logic [CNT_W-1:0]     r_word_cnt;
  logic [TILE_W-1:0]    r_tile;
  logic                 r_bank;
  logic                 r_swap;
  logic [A_W-1:0]       r_wraddr;
  logic [M_W-1:0]       r_wrdata;
  logic [NUM_TILES-1:0] r_bram1_wren;
  logic [NUM_TILES-1:0] r_bram2_wren;
  logic [NUM_TILES-1:0] r_ld_new;
  logic                 r_done;
  logic                 r_cmd_err;

  logic [NUM_TILES-1:0] w_tile_oh;
  logic                 w_cmd_ready;
  logic                 w_s_ready;
  logic                 w_cmd_fire;
  logic                 w_tile_ok;
  logic                 w_beat;
  logic                 w_last;

  dsp_onehot_dec #(
    .N (NUM_TILES),
    .W (TILE_W)
  ) u_tile_dec (
    .i_en     (ce),
    .i_idx    (r_tile),
    .o_onehot (w_tile_oh)
  );

  // Handshakes are gated by rst so nothing is accepted on a reset edge.
  assign w_cmd_ready = (r_state == IDLE) && ce && !rst;
  assign w_s_ready   = (r_state == LOAD) && ce && !rst;
  assign w_cmd_fire  = cmd_valid && w_cmd_ready;
  assign w_tile_ok   = ({1'b0, cmd_tile} < TILE_LIM);
  assign w_beat      = s_valid && w_s_ready;
  assign w_last      = (r_word_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (ce) begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire && w_tile_ok) begin
            w_state_next = LOAD;
          end
        end
        LOAD: begin
          if (w_beat && w_last) begin
            w_state_next = r_swap ? SWAP : DONE;
          end
        end
        SWAP:    w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Strobes default low each cycle; with ce low every update below is skipped,
  // so the strobes drop while the counter and latched command hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt   <= '0;
      r_tile       <= '0;
      r_bank       <= 1'b0;
      r_swap       <= 1'b0;
      r_wraddr     <= '0;
      r_wrdata     <= '0;
      r_bram1_wren <= '0;
      r_bram2_wren <= '0;
      r_ld_new     <= '0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_bram1_wren <= '0;
      r_bram2_wren <= '0;
      r_ld_new     <= '0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
      if (w_cmd_fire) begin
        if (w_tile_ok) begin
          r_tile     <= cmd_tile;
          r_bank     <= cmd_bank;
          r_swap     <= cmd_swap;
          r_word_cnt <= '0;
        end else begin
          r_cmd_err <= 1'b1;
        end
      end
      if (w_beat) begin
        r_wraddr <= A_W'(r_word_cnt);
        r_wrdata <= s_data;
        if (r_bank) begin
          r_bram2_wren <= w_tile_oh;
        end else begin
          r_bram1_wren <= w_tile_oh;
        end
        // The final word leaves the counter parked rather than wrapping.
        if (!w_last) begin
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
      end
      if (ce && (r_state == SWAP)) begin
        r_ld_new <= w_tile_oh;
      end
      if (ce && (r_state == DONE)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign cmd_ready       = w_cmd_ready;
  assign s_ready         = w_s_ready;
  assign busy            = (r_state != IDLE);
  assign krnl_wraddr     = r_wraddr;
  assign krnl_wrdata     = r_wrdata;
  assign krnl_bram1_wren = r_bram1_wren;
  assign krnl_bram2_wren = r_bram2_wren;
  assign ld_new_kernel   = r_ld_new;
  assign done            = r_done;
  assign cmd_err         = r_cmd_err;

endmodule

// File: tb/tb_dsp_krnl_load_ctrl.sv
// Directed bench for dsp_krnl_load_ctrl: main instance with 8 tiles, plus a 9-tile
// instance whose 4-bit tile port can express an out-of-range index.
module tb_dsp_krnl_load_ctrl;

  localparam int NT = 8;
  localparam int AW = 14;
  localparam int MW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ce;
  logic          cmd_valid, cmd_bank, cmd_swap, s_valid;
  logic [2:0]    cmd_tile;
  logic [MW-1:0] s_data;
  logic          cmd_ready, s_ready, busy, done, cmd_err;
  logic [AW-1:0] wraddr;
  logic [MW-1:0] wrdata;
  logic [NT-1:0] wren1, wren2, ldk;

  logic          d2_cmd_valid;
  logic [3:0]    d2_cmd_tile;
  logic          d2_cmd_ready, d2_s_ready, d2_busy, d2_done, d2_cmd_err;
  logic [AW-1:0] d2_wraddr;
  logic [MW-1:0] d2_wrdata;
  logic [8:0]    d2_wren1, d2_wren2, d2_ldk;

  dsp_krnl_load_ctrl #(.NUM_TILES(NT)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tile(cmd_tile),
    .cmd_bank(cmd_bank), .cmd_swap(cmd_swap),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .krnl_wraddr(wraddr), .krnl_wrdata(wrdata),
    .krnl_bram1_wren(wren1), .krnl_bram2_wren(wren2),
    .ld_new_kernel(ldk), .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  dsp_krnl_load_ctrl #(.NUM_TILES(9)) dut_err (
    .clk(clk), .rst(rst), .ce(ce),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_tile(d2_cmd_tile),
    .cmd_bank(1'b0), .cmd_swap(1'b0),
    .s_valid(1'b0), .s_ready(d2_s_ready), .s_data({MW{1'b0}}),
    .krnl_wraddr(d2_wraddr), .krnl_wrdata(d2_wrdata),
    .krnl_bram1_wren(d2_wren1), .krnl_bram2_wren(d2_wren2),
    .ld_new_kernel(d2_ldk), .busy(d2_busy), .done(d2_done), .cmd_err(d2_cmd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event log, sampled on the falling edge.
  int            cyc = 0, n_wr = 0, n_ld = 0, n_done = 0, n_err = 0, n_multi = 0;
  int            n_err2 = 0, n_wr2 = 0;
  logic [AW-1:0] m_addr [1024];
  logic [MW-1:0] m_data [1024];
  logic [NT-1:0] m_v1   [1024];
  logic [NT-1:0] m_v2   [1024];
  int            m_cyc  [1024];
  logic [NT-1:0] ld_vec_last;
  int            ld_cyc_last, done_cyc_last;

  always @(negedge clk) begin
    if (((wren1 | wren2) != '0) && (n_wr < 1024)) begin
      m_addr[n_wr] <= wraddr;
      m_data[n_wr] <= wrdata;
      m_v1[n_wr]   <= wren1;
      m_v2[n_wr]   <= wren2;
      m_cyc[n_wr]  <= cyc;
      n_wr         <= n_wr + 1;
    end
    if (($countones(wren1) + $countones(wren2) > 1) || ($countones(ldk) > 1))
      n_multi <= n_multi + 1;
    if (ldk != '0) begin
      n_ld        <= n_ld + 1;
      ld_vec_last <= ldk;
      ld_cyc_last <= cyc;
    end
    if (done === 1'b1) begin
      n_done        <= n_done + 1;
      done_cyc_last <= cyc;
    end
    if (cmd_err === 1'b1)    n_err  <= n_err + 1;
    if (d2_cmd_err === 1'b1) n_err2 <= n_err2 + 1;
    if ((d2_wren1 | d2_wren2) != '0) n_wr2 <= n_wr2 + 1;
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [2:0] t, input logic b, input logic s, output bit acc);
    bit rdy;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_tile = t; cmd_bank = b; cmd_swap = s;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      rdy = cmd_ready;
      tick();
      acc = rdy;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int off, input bit toggle, input int freeze_after,
                      output int got);
    int w, budget;
    bit gap, fire;
    w = 0; gap = 1'b0; got = 0; budget = 0;
    while (got < n && budget < 1000) begin
      budget++;
      s_valid = !(toggle && gap);
      s_data  = MW'(w + off);
      #1;
      fire = s_valid && s_ready;
      tick();
      gap = !gap;
      if (fire) begin
        got++;
        w++;
        if (got - 1 == freeze_after) begin
          ce = 1'b0; s_valid = 1'b1; s_data = MW'(w + off);
          repeat (4) tick();
          ce = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1;
    cmd_valid = 1'b0; cmd_tile = '0; cmd_bank = 1'b0; cmd_swap = 1'b0;
    s_valid = 1'b0; s_data = '0; d2_cmd_valid = 1'b0; d2_cmd_tile = '0;
    repeat (3) tick();
    n_tests++;
    if ({wren1, wren2, ldk} !== '0) begin
      n_fail++; $display("FAIL reset_vectors got=%h want=0", {wren1, wren2, ldk});
    end
    n_tests++;
    if ({done, cmd_err, busy, s_ready, cmd_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=00000", {done, cmd_err, busy, s_ready, cmd_ready});
    end
    n_tests++;
    if (wraddr !== '0 || wrdata !== '0) begin
      n_fail++; $display("FAIL reset_bus addr=%0d data=%0d want 0/0", wraddr, wrdata);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({cmd_ready, s_ready, busy, d2_cmd_ready} !== 4'b1001) begin
      n_fail++; $display("FAIL idle_ready got=%b want=1001", {cmd_ready, s_ready, busy, d2_cmd_ready});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_swap_load();
    int base, ld0, dn0, got, last;
    bit acc;
    base = n_wr; ld0 = n_ld; dn0 = n_done;
    issue_cmd(3'd5, 1'b0, 1'b1, acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL swap_accept got=%b want=1", acc); end
    feed(54, 0, 1'b0, -1, got);
    repeat (4) tick();
    n_tests++;
    if (got !== 54 || n_wr - base !== 54) begin
      n_fail++; $display("FAIL swap_count beats=%0d writes=%0d want 54", got, n_wr - base);
    end
    for (int i = 0; i < 54; i++) begin
      n_tests++;
      if (m_addr[base+i] !== AW'(i) || m_data[base+i] !== MW'(i) || m_v1[base+i] !== 8'h20 ||
          m_v2[base+i] !== 8'h00 || m_cyc[base+i] !== m_cyc[base] + i) begin
        n_fail++;
        $display("FAIL swap_write%0d addr=%0d data=%0d v1=%h v2=%h want addr=%0d data=%0d v1=20 v2=00",
                 i, m_addr[base+i], m_data[base+i], m_v1[base+i], m_v2[base+i], i, i);
      end
    end
    last = m_cyc[base+53];
    n_tests++;
    if (n_ld - ld0 !== 1 || ld_vec_last !== 8'h20 || ld_cyc_last !== last + 1) begin
      n_fail++; $display("FAIL swap_ldk count=%0d vec=%h dcyc=%0d want 1/20/1", n_ld - ld0, ld_vec_last, ld_cyc_last - last);
    end
    n_tests++;
    if (n_done - dn0 !== 1 || done_cyc_last !== last + 2) begin
      n_fail++; $display("FAIL swap_done count=%0d dcyc=%0d want 1/2", n_done - dn0, done_cyc_last - last);
    end
    $display("[TB] load tile=5 bank=0 swap=1 writes=%0d", n_wr - base);
  endtask

  task automatic test_toggle();
    int base, ld0, dn0, got, last;
    bit acc;
    base = n_wr; ld0 = n_ld; dn0 = n_done;
    issue_cmd(3'd2, 1'b1, 1'b0, acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL toggle_accept got=%b want=1", acc); end
    feed(54, 1000, 1'b1, -1, got);
    repeat (4) tick();
    n_tests++;
    if (got !== 54 || n_wr - base !== 54) begin
      n_fail++; $display("FAIL toggle_count beats=%0d writes=%0d want 54", got, n_wr - base);
    end
    for (int i = 0; i < 54; i++) begin
      n_tests++;
      if (m_addr[base+i] !== AW'(i) || m_data[base+i] !== MW'(i + 1000) || m_v1[base+i] !== 8'h00 ||
          m_v2[base+i] !== 8'h04 || m_cyc[base+i] !== m_cyc[base] + 2 * i) begin
        n_fail++;
        $display("FAIL toggle_write%0d addr=%0d data=%0d v1=%h v2=%h want addr=%0d data=%0d v1=00 v2=04",
                 i, m_addr[base+i], m_data[base+i], m_v1[base+i], m_v2[base+i], i, i + 1000);
      end
    end
    last = m_cyc[base+53];
    n_tests++;
    if (n_ld !== ld0) begin n_fail++; $display("FAIL toggle_no_ldk count=%0d want 0", n_ld - ld0); end
    n_tests++;
    if (n_done - dn0 !== 1 || done_cyc_last !== last + 1) begin
      n_fail++; $display("FAIL toggle_done count=%0d dcyc=%0d want 1/1", n_done - dn0, done_cyc_last - last);
    end
    $display("[TB] load tile=2 bank=1 swap=0 writes=%0d", n_wr - base);
  endtask

  task automatic test_bad_tile();
    int e0;
    e0 = n_err2;
    d2_cmd_valid = 1'b1; d2_cmd_tile = 4'd9;
    #1;
    n_tests++;
    if (d2_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready got=%b want=1", d2_cmd_ready); end
    tick();
    d2_cmd_valid = 1'b0;
    n_tests++;
    if (d2_cmd_err !== 1'b1 || d2_busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_err err=%b busy=%b want 1/0", d2_cmd_err, d2_busy);
    end
    tick();
    n_tests++;
    if (d2_cmd_err !== 1'b0 || d2_busy !== 1'b0 || d2_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bad_idle err=%b busy=%b ready=%b want 0/0/1", d2_cmd_err, d2_busy, d2_cmd_ready);
    end
    repeat (3) tick();
    n_tests++;
    if (n_err2 - e0 !== 1 || n_wr2 !== 0 || d2_ldk !== '0 || d2_done !== 1'b0) begin
      n_fail++; $display("FAIL bad_totals errs=%0d wr=%0d want 1/0", n_err2 - e0, n_wr2);
    end
    $display("[TB] cmd tile=9 rejected errs=%0d", n_err2 - e0);
  endtask

  task automatic test_ce_freeze();
    int base, dn0, got, exp_cyc;
    bit acc;
    base = n_wr; dn0 = n_done;
    issue_cmd(3'd6, 1'b0, 1'b0, acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL freeze_accept got=%b want=1", acc); end
    feed(54, 2000, 1'b0, 20, got);
    repeat (4) tick();
    n_tests++;
    if (got !== 54 || n_wr - base !== 54) begin
      n_fail++; $display("FAIL freeze_count beats=%0d writes=%0d want 54", got, n_wr - base);
    end
    for (int i = 0; i < 54; i++) begin
      exp_cyc = m_cyc[base] + i + ((i > 20) ? 4 : 0);
      n_tests++;
      if (m_addr[base+i] !== AW'(i) || m_data[base+i] !== MW'(i + 2000) ||
          m_v1[base+i] !== 8'h40 || m_cyc[base+i] !== exp_cyc) begin
        n_fail++;
        $display("FAIL freeze_write%0d addr=%0d data=%0d v1=%h cyc=%0d want addr=%0d data=%0d v1=40 cyc=%0d",
                 i, m_addr[base+i], m_data[base+i], m_v1[base+i], m_cyc[base+i], i, i + 2000, exp_cyc);
      end
    end
    n_tests++;
    if (n_done - dn0 !== 1) begin n_fail++; $display("FAIL freeze_done count=%0d want 1", n_done - dn0); end
    $display("[TB] load tile=6 bank=0 swap=0 ce-freeze writes=%0d", n_wr - base);
  endtask

  task automatic test_reset_mid();
    int base, ld0, dn0, got;
    bit acc;
    base = n_wr; ld0 = n_ld; dn0 = n_done;
    issue_cmd(3'd4, 1'b1, 1'b1, acc);
    feed(30, 3000, 1'b0, -1, got);
    n_tests++;
    if (acc !== 1'b1 || got !== 30) begin
      n_fail++; $display("FAIL abort_pre acc=%b beats=%0d want 1/30", acc, got);
    end
    rst = 1'b1; s_valid = 1'b1; s_data = MW'(3030);
    tick();
    n_tests++;
    if ({wren1, wren2, ldk} !== '0 || wraddr !== '0 || wrdata !== '0) begin
      n_fail++; $display("FAIL abort_outputs vec=%h addr=%0d data=%0d want 0", {wren1, wren2, ldk}, wraddr, wrdata);
    end
    n_tests++;
    if ({done, cmd_err, busy, s_ready, cmd_ready} !== 5'b0) begin
      n_fail++; $display("FAIL abort_flags got=%b want=00000", {done, cmd_err, busy, s_ready, cmd_ready});
    end
    rst = 1'b0; s_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (n_wr - base !== 30 || n_ld !== ld0 || n_done !== dn0) begin
      n_fail++; $display("FAIL abort_quiet writes=%0d ldk=%0d done=%0d want 30/0/0", n_wr - base, n_ld - ld0, n_done - dn0);
    end
    $display("[TB] load tile=4 bank=1 swap=1 aborted writes=%0d", n_wr - base);
    base = n_wr; dn0 = n_done;
    issue_cmd(3'd0, 1'b0, 1'b0, acc);
    feed(54, 4000, 1'b0, -1, got);
    repeat (4) tick();
    n_tests++;
    if (acc !== 1'b1 || n_wr - base !== 54 || n_done - dn0 !== 1) begin
      n_fail++; $display("FAIL reload_totals acc=%b writes=%0d done=%0d want 1/54/1", acc, n_wr - base, n_done - dn0);
    end
    for (int i = 0; i < 54; i++) begin
      n_tests++;
      if (m_addr[base+i] !== AW'(i) || m_data[base+i] !== MW'(i + 4000) || m_v1[base+i] !== 8'h01) begin
        n_fail++;
        $display("FAIL reload_write%0d addr=%0d data=%0d v1=%h want addr=%0d data=%0d v1=01",
                 i, m_addr[base+i], m_data[base+i], m_v1[base+i], i, i + 4000);
      end
    end
    $display("[TB] load tile=0 bank=0 swap=0 after reset writes=%0d", n_wr - base);
  endtask

  task automatic test_back_to_back();
    int base, base2, e0, got;
    bit acc;
    base = n_wr; e0 = n_err;
    issue_cmd(3'd1, 1'b0, 1'b0, acc);
    cmd_valid = 1'b1; cmd_tile = 3'd3; cmd_bank = 1'b1; cmd_swap = 1'b0;
    #1;
    n_tests++;
    if (acc !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_load_ready acc=%b ready=%b want 1/0", acc, cmd_ready);
    end
    feed(54, 5000, 1'b0, -1, got);
    #1;
    n_tests++;
    if (got !== 54 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done_state beats=%0d ready=%b busy=%b want 54/0/1", got, cmd_ready, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle done=%b busy=%b ready=%b want 1/0/1", done, busy, cmd_ready);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept busy=%b ready=%b want 1/0", busy, cmd_ready);
    end
    cmd_valid = 1'b0;
    base2 = n_wr;
    n_tests++;
    if (base2 - base !== 54) begin n_fail++; $display("FAIL b2b_first_count writes=%0d want 54", base2 - base); end
    for (int i = 0; i < 54; i++) begin
      n_tests++;
      if (m_addr[base+i] !== AW'(i) || m_v1[base+i] !== 8'h02 || m_v2[base+i] !== 8'h00) begin
        n_fail++; $display("FAIL b2b_first%0d addr=%0d v1=%h v2=%h want addr=%0d v1=02 v2=00",
                           i, m_addr[base+i], m_v1[base+i], m_v2[base+i], i);
      end
    end
    feed(54, 6000, 1'b0, -1, got);
    repeat (4) tick();
    n_tests++;
    if (n_wr - base2 !== 54 || n_err !== e0) begin
      n_fail++; $display("FAIL b2b_second_count writes=%0d errs=%0d want 54/0", n_wr - base2, n_err - e0);
    end
    for (int i = 0; i < 54; i++) begin
      n_tests++;
      if (m_addr[base2+i] !== AW'(i) || m_data[base2+i] !== MW'(i + 6000) ||
          m_v1[base2+i] !== 8'h00 || m_v2[base2+i] !== 8'h08) begin
        n_fail++; $display("FAIL b2b_second%0d addr=%0d data=%0d v2=%h want addr=%0d data=%0d v2=08",
                           i, m_addr[base2+i], m_data[base2+i], m_v2[base2+i], i, i + 6000);
      end
    end
    $display("[TB] load tile=1 then tile=3 bank=1 back-to-back writes=%0d", n_wr - base);
  endtask

  task automatic test_onehot();
    n_tests++;
    if (n_multi !== 0) begin n_fail++; $display("FAIL onehot_violations got=%0d want 0", n_multi); end
    n_tests++;
    if (n_err !== 0) begin n_fail++; $display("FAIL main_cmd_err got=%0d want 0", n_err); end
  endtask

  initial begin
    test_reset();
    test_swap_load();
    test_toggle();
    test_bad_tile();
    test_ce_freeze();
    test_reset_mid();
    test_back_to_back();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
